// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU: execute resolution kinds,
// branch conditions, flag bit positions and the fetch sequencer FSM states.
package cpu_pkg;

    // Resolution kinds presented by execute (6/7 fall back to sequential)
    localparam logic [2:0] RES_SEQ    = 3'd0;
    localparam logic [2:0] RES_JUMP   = 3'd1;
    localparam logic [2:0] RES_BRANCH = 3'd2;
    localparam logic [2:0] RES_CALL   = 3'd3;
    localparam logic [2:0] RES_RET    = 3'd4;
    localparam logic [2:0] RES_HALT   = 3'd5;

    // Branch conditions
    localparam logic [2:0] COND_Z      = 3'd0;
    localparam logic [2:0] COND_NZ     = 3'd1;
    localparam logic [2:0] COND_C      = 3'd2;
    localparam logic [2:0] COND_NC     = 3'd3;
    localparam logic [2:0] COND_S      = 3'd4;
    localparam logic [2:0] COND_NS     = 3'd5;
    localparam logic [2:0] COND_ALWAYS = 3'd6;
    localparam logic [2:0] COND_NEVER  = 3'd7;

    // Bit positions inside flags = {carry, zero, sign}
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_SIGN  = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4
    } fsm_state_t;

    // True when the branch condition holds for the given flags
    function automatic logic cond_met(input logic [2:0] cond, input logic [2:0] flags);
        logic r;
        case (cond)
            COND_Z:      r = flags[FLAG_ZERO];
            COND_NZ:     r = !flags[FLAG_ZERO];
            COND_C:      r = flags[FLAG_CARRY];
            COND_NC:     r = !flags[FLAG_CARRY];
            COND_S:      r = flags[FLAG_SIGN];
            COND_NS:     r = !flags[FLAG_SIGN];
            COND_ALWAYS: r = 1'b1;
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, instruction memory, decode and
// execute. master = sequencer side, slave = memory/decode/execute side.
interface pc_fetch_sequencer_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    // instruction memory handshake
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_valid;
    logic [INSTR_W-1:0] imem_data;
    // decode handshake
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    // execute resolution
    logic               res_valid;
    logic [2:0]         res_kind;
    logic [2:0]         res_cond;
    logic [ADDR_W-1:0]  res_target;
    logic [2:0]         flags;

    modport master (
        output imem_req, imem_addr, instr, instr_valid,
        input  imem_valid, imem_data, instr_ready,
        input  res_valid, res_kind, res_cond, res_target, flags
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid,
        output imem_valid, imem_data, instr_ready,
        output res_valid, res_kind, res_cond, res_target, flags
    );
endinterface

// File: rtl/ret_addr_stack.sv
// Return-address LIFO. Pointer addresses the next free slot; count tracks
// occupancy so full/empty are unambiguous at STACK_DEPTH entries.
module ret_addr_stack #(
    parameter int ADDR_W      = 32,
    parameter int STACK_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [PTR_W-1:0]  ptr_q;
    logic [CNT_W-1:0]  cnt_q;

    assign full  = (cnt_q == CNT_W'(STACK_DEPTH));
    assign empty = (cnt_q == '0);
    assign top   = mem[ptr_q - PTR_W'(1)];

    // Pointer/occupancy update; the caller never asks to push full or pop empty
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push && !full) begin
            ptr_q <= ptr_q + PTR_W'(1);
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (pop && !empty) begin
            ptr_q <= ptr_q - PTR_W'(1);
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Storage write; contents need no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[ptr_q] <= push_data;
    end
endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner for the multi-cycle CPU: fetches one instruction,
// hands it to decode, waits for execute to resolve the next PC, repeats.
module pc_fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int              ADDR_W       = 32,
    parameter int              INSTR_W      = 32,
    parameter int              STACK_DEPTH  = 8,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               haltext,
    pc_fetch_sequencer_if.master bus,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic               err_overflow,
    output logic               err_underflow
);
    fsm_state_t         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_seq, pc_next;
    logic [INSTR_W-1:0] instr_q;
    logic               hard_halt_q;   // halt that only reset can leave
    logic               resolve;
    logic               fatal;
    logic               set_ovf, set_unf;
    logic               push, pop;
    logic [ADDR_W-1:0]  stk_top;
    logic               stk_full, stk_empty;

    assign resolve = (state_q == ST_EXEC) && bus.res_valid;

    ret_addr_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_seq),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Next-PC resolution and stack control for the instruction in EXEC
    always_comb begin
        pc_seq  = pc_q + ADDR_W'(4);
        pc_next = pc_seq;
        push    = 1'b0;
        pop     = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        fatal   = 1'b0;
        case (bus.res_kind)
            RES_JUMP:   pc_next = bus.res_target;
            RES_BRANCH: pc_next = cond_met(bus.res_cond, bus.flags) ? bus.res_target : pc_seq;
            RES_CALL: begin
                if (stk_full) begin
                    pc_next = pc_q;
                    set_ovf = 1'b1;
                    fatal   = 1'b1;
                end else begin
                    push    = resolve;
                    pc_next = bus.res_target;
                end
            end
            RES_RET: begin
                if (stk_empty) begin
                    pc_next = pc_q;
                    set_unf = 1'b1;
                    fatal   = 1'b1;
                end else begin
                    pop     = resolve;
                    pc_next = stk_top;
                end
            end
            RES_HALT: begin
                pc_next = pc_q;
                fatal   = 1'b1;
            end
            default: pc_next = pc_seq;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; haltext only matters at instruction boundaries
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = haltext ? ST_HALT : ST_FETCH;
            ST_FETCH: if (bus.imem_valid) state_d = ST_ISSUE;
            ST_ISSUE: if (bus.instr_ready) state_d = ST_EXEC;
            ST_EXEC: begin
                if (bus.res_valid) begin
                    if (fatal || haltext) state_d = ST_HALT;
                    else                  state_d = ST_FETCH;
                end
            end
            ST_HALT:  if (!hard_halt_q && !haltext) state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        bus.imem_req    = (state_q == ST_FETCH);
        bus.instr_valid = (state_q == ST_ISSUE);
        bus.imem_addr   = pc_q;
        bus.instr       = instr_q;
        halted          = (state_q == ST_HALT);
        pc              = pc_q;
    end

    // PC, instruction capture and sticky error/halt flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q          <= RESET_VECTOR;
            instr_q       <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            hard_halt_q   <= 1'b0;
        end else begin
            if (state_q == ST_FETCH && bus.imem_valid)
                instr_q <= bus.imem_data;
            if (resolve) begin
                pc_q <= pc_next;
                if (set_ovf) err_overflow  <= 1'b1;
                if (set_unf) err_underflow <= 1'b1;
                if (fatal)   hard_halt_q   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: drives memory/decode/execute at
// negedge, samples outputs at negedge, expected values are hand-derived.
module tb_pc_fetch_sequencer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        haltext = 1'b0;
    logic [31:0] pc;
    logic        halted, err_overflow, err_underflow;
    int          checks = 0;
    int          errors = 0;

    pc_fetch_sequencer_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

    pc_fetch_sequencer #(
        .ADDR_W(32), .INSTR_W(32), .STACK_DEPTH(8), .RESET_VECTOR(32'h0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .haltext       (haltext),
        .bus           (bus),
        .pc            (pc),
        .halted        (halted),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Fetch at expected address (memory answers 2 cycles later), hand to
    // decode; optionally raise haltext while the instruction sits in ISSUE.
    task automatic fetch_issue(input logic [31:0] addr, input logic raise_halt);
        int n = 0;
        while (!bus.imem_req && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", bus.imem_req, 1);
        chk("imem_addr", bus.imem_addr, addr);
        tick();
        tick();
        bus.imem_valid = 1'b1;
        bus.imem_data  = word_of(addr);
        tick();
        bus.imem_valid = 1'b0;
        bus.imem_data  = '0;
        chk("instr_valid_hi", bus.instr_valid, 1);
        chk("instr", bus.instr, word_of(addr));
        haltext = raise_halt;
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        chk("instr_valid_lo", bus.instr_valid, 0);
    endtask

    task automatic resolve(input logic [2:0] kind, input logic [2:0] cond,
                           input logic [31:0] target, input logic [2:0] fl);
        bus.res_valid  = 1'b1;
        bus.res_kind   = kind;
        bus.res_cond   = cond;
        bus.res_target = target;
        bus.flags      = fl;
        tick();
        bus.res_valid  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        bus.imem_valid = 1'b0; bus.imem_data = '0; bus.instr_ready = 1'b0;
        bus.res_valid = 1'b0; bus.res_kind = '0; bus.res_cond = '0;
        bus.res_target = '0; bus.flags = '0;

        // reset state
        tick();
        chk("rst_pc", pc, 0);
        chk("rst_req", bus.imem_req, 0);
        chk("rst_ivalid", bus.instr_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_ovf", err_overflow, 0);
        chk("rst_unf", err_underflow, 0);
        tick();
        reset = 1'b1;
        tick();

        // 1: sequential fetches
        fetch_issue(32'h0, 0); resolve(RES_SEQ, 0, 0, 0);
        fetch_issue(32'h4, 0); resolve(RES_SEQ, 0, 0, 0);
        fetch_issue(32'h8, 0); resolve(RES_SEQ, 0, 0, 0);
        chk("seq_pc", pc, 32'hC);

        // 2: branches
        fetch_issue(32'hC, 0);  resolve(RES_BRANCH, COND_Z, 32'h40, 3'b010);
        chk("br_z_taken", pc, 32'h40);
        fetch_issue(32'h40, 0); resolve(RES_BRANCH, COND_Z, 32'h80, 3'b000);
        chk("br_z_not", pc, 32'h44);
        fetch_issue(32'h44, 0); resolve(RES_BRANCH, COND_NEVER, 32'h80, 3'b111);
        chk("br_never", pc, 32'h48);
        fetch_issue(32'h48, 0); resolve(RES_BRANCH, COND_ALWAYS, 32'h10, 3'b000);
        chk("br_always", pc, 32'h10);

        // 3: call/return, then overflow
        fetch_issue(32'h10, 0);  resolve(RES_CALL, 0, 32'h100, 0);
        chk("call_pc", pc, 32'h100);
        fetch_issue(32'h100, 0); resolve(RES_RET, 0, 0, 0);
        chk("ret_pc", pc, 32'h14);
        for (int i = 0; i < 8; i++) begin
            fetch_issue(i == 0 ? 32'h14 : 32'h1000 + 32'(i - 1) * 32'h100, 0);
            resolve(RES_CALL, 0, 32'h1000 + 32'(i) * 32'h100, 0);
        end
        fetch_issue(32'h1700, 0); resolve(RES_CALL, 0, 32'h2000, 0);
        chk("ovf_err", err_overflow, 1);
        chk("ovf_halted", halted, 1);
        chk("ovf_pc", pc, 32'h1700);
        tick(); tick();
        chk("ovf_noreq", bus.imem_req, 0);
        chk("ovf_stay", halted, 1);

        // 4: underflow
        do_reset();
        chk("rst2_ovf", err_overflow, 0);
        fetch_issue(32'h0, 0); resolve(RES_RET, 0, 0, 0);
        chk("unf_err", err_underflow, 1);
        chk("unf_halted", halted, 1);
        chk("unf_pc", pc, 0);
        tick(); tick(); tick();
        chk("unf_noreq", bus.imem_req, 0);
        chk("unf_stay", halted, 1);
        do_reset();
        chk("unf_cleared", err_underflow, 0);
        chk("unf_unhalt", halted, 0);

        // 5: external halt then resume; HALT kind is permanent
        fetch_issue(32'h0, 1); resolve(RES_SEQ, 0, 0, 0);
        chk("hx_halted", halted, 1);
        chk("hx_pc", pc, 32'h4);
        chk("hx_noreq", bus.imem_req, 0);
        tick(); tick();
        chk("hx_hold", halted, 1);
        haltext = 1'b0;
        tick();
        chk("hx_resume_req", bus.imem_req, 1);
        chk("hx_resume_addr", bus.imem_addr, 32'h4);
        chk("hx_resume_unhalt", halted, 0);
        fetch_issue(32'h4, 0); resolve(RES_HALT, 0, 0, 0);
        chk("hk_halted", halted, 1);
        chk("hk_pc", pc, 32'h4);
        haltext = 1'b1; tick(); haltext = 1'b0; tick(); tick();
        chk("hk_stay", halted, 1);
        chk("hk_noreq", bus.imem_req, 0);

        // 6: reset mid-FETCH ignores late data and empties the stack
        do_reset();
        fetch_issue(32'h0, 0); resolve(RES_CALL, 0, 32'h50, 0);
        chk("r6_req", bus.imem_req, 1);
        chk("r6_addr", bus.imem_addr, 32'h50);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus.imem_valid = 1'b1;
        bus.imem_data  = 32'hDEAD_BEEF;
        chk("r6_pc", pc, 0);
        chk("r6_req_lo", bus.imem_req, 0);
        tick();
        bus.imem_valid = 1'b0;
        bus.imem_data  = '0;
        chk("r6_restart", bus.imem_req, 1);
        chk("r6_instr", bus.instr, 0);
        chk("r6_ivalid", bus.instr_valid, 0);
        fetch_issue(32'h0, 0); resolve(RES_RET, 0, 0, 0);
        chk("r6_stack_empty", err_underflow, 1);

        // PC wrap
        do_reset();
        fetch_issue(32'h0, 0); resolve(RES_JUMP, 0, 32'hFFFF_FFFC, 0);
        chk("jmp_pc", pc, 32'hFFFF_FFFC);
        fetch_issue(32'hFFFF_FFFC, 0); resolve(RES_SEQ, 0, 0, 0);
        chk("wrap_pc", pc, 0);
        fetch_issue(32'h0, 0); resolve(3'd7, 0, 32'h500, 0);
        chk("kind7_seq", pc, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got 0 exp 1");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Parametrised successor to the program counter and jump logic of the single-cycle CPU. It owns the PC, runs a multi-cycle fetch handshake with instruction memory, and hands each instruction to decode.
- It resolves next-PC from execute: sequential, jump, conditional branch on flags, call/return via an internal return-address stack, and halt.
- It sits between the instruction memory and the control/datapath units of the multi-cycle CPU top.

Parameters:
ADDR_W, 32, PC/address width
INSTR_W, 32, instruction width
STACK_DEPTH, 8, return-address stack entries (power of two, >=2)
RESET_VECTOR, 0, PC value after reset

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
haltext  in  1  external halt request (level)
imem_req  out  1  fetch request, held until imem_valid
imem_addr  out  ADDR_W  fetch address (= pc)
imem_valid  in  1  instruction memory data valid
imem_data  in  INSTR_W  fetched instruction
instr  out  INSTR_W  instruction to decode (registered)
instr_valid  out  1  instr valid, held until instr_ready
instr_ready  in  1  decode accepts instr
res_valid  in  1  execute resolution strobe (1 cycle)
res_kind  in  3  0 SEQ, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5 HALT, 6/7 treated as SEQ
res_cond  in  3  branch condition
res_target  in  ADDR_W  jump/branch/call target
flags  in  3  {carry, zero, sign}
pc  out  ADDR_W  current PC
halted  out  1  in HALT state
err_overflow  out  1  sticky: CALL with stack full
err_underflow  out  1  sticky: RET with stack empty

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, pc=RESET_VECTOR, stack empty, all outputs 0, sticky bits cleared. Applies in any state and aborts any in-flight fetch. imem_req is low the cycle after reset is sampled.
- FSM states: IDLE, FETCH, ISSUE, EXEC, HALT. One instruction is in flight; there is no pipelining.
- IDLE: one cycle, then goes to FETCH, or to HALT if haltext=1.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - On imem_valid: capture imem_data into instr, go to ISSUE.
  - imem_valid in any other state is ignored.
- ISSUE:
  - instr_valid=1.
  - On instr_ready: drop instr_valid next cycle, go to EXEC.
  - instr is stable while valid.
- EXEC: wait for res_valid. When it arrives, compute next pc (all arithmetic modulo 2^ADDR_W, so pc+4 wraps):
  - SEQ: pc+4.
  - JUMP: res_target.
  - BRANCH: res_target if the condition holds, else pc+4. Conditions: 0 zero, 1 !zero, 2 carry, 3 !carry, 4 sign, 5 !sign, 6 always, 7 never.
  - CALL, stack not full: push pc+4, pc=res_target.
  - CALL, stack full: no push, pc unchanged, set err_overflow, go to HALT.
  - RET, stack not empty: pc=pop.
  - RET, stack empty: pc unchanged, set err_underflow, go to HALT.
  - HALT: pc unchanged, go to HALT (sticky).
  - Otherwise go to FETCH, or to HALT if haltext=1 that cycle.
- haltext is sampled only at instruction boundaries (IDLE exit, EXEC resolution, and in HALT). The current instruction always completes.
- HALT: halted=1, imem_req=0.
  - If entered by haltext only, resume to FETCH at the current pc the cycle after haltext samples 0.
  - If entered by res_kind HALT or an error, stay until reset.
- The stack is a LIFO of STACK_DEPTH entries with a pointer and count. Push and pop never coincide, since there is one resolution per instruction.
- res_valid outside EXEC is ignored.

Decomposition:
- Shared package cpu_pkg holds:
  - res_kind encodings (RES_SEQ..RES_HALT)
  - condition encodings (COND_Z..COND_NEVER)
  - flag bit indices (FLAG_CARRY=2, FLAG_ZERO=1, FLAG_SIGN=0)
  - FSM state enum
- One natural sub-module: ret_addr_stack, parametrised by ADDR_W and STACK_DEPTH. It has push/pop/full/empty/top ports and synchronous active-low reset.

Test Plan:
1. Reset release, imem answers each request 2 cycles later, instr_ready immediate, res_kind SEQ each time -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid pulses once per fetched word.
2. BRANCH cond=0 with target 0x40: flags=3'b010 -> pc=0x40; flags=3'b000 -> pc=pc+4. Cond 7 never branches; cond 6 always branches.
3. CALL 0x100 from pc=0x10, then RET -> pc 0x100, then 0x14. Nine nested CALLs with depth 8 -> err_overflow=1, halted=1, pc holds the 9th CALL address.
4. RET on empty stack -> err_underflow=1, halted=1, no further imem_req; only reset clears it.
5. haltext raised during ISSUE -> instruction completes, halted=1, pc=next pc. Lower haltext -> fetch resumes at that pc one cycle later. res_kind HALT -> halted stays 1 regardless of haltext.
6. reset low mid-FETCH with imem_valid arriving the next cycle -> data ignored, pc=RESET_VECTOR, stack empty, fetch restarts at RESET_VECTOR. Also pc=0xFFFFFFFC with SEQ -> wraps to 0x0.
